// File: rtl/tick_period_monitor.sv
// tick_period_monitor
// Watches the one-cycle tick from the upstream periodic generator and
// measures the interval between consecutive ticks. It locks after LOCK
// in-tolerance intervals in a row. It reports early and late ticks with
// one-cycle pulses, and once locked any deviation latches a sticky fault
// that only clr releases. The tick and error counters are exposed so
// that benches can observe them.
module tick_period_monitor #(
   parameter int PERIOD = 1251,  // nominal tick-to-tick interval in cycles
   parameter int TOL    = 0,     // allowed deviation, either direction
   parameter int LOCK   = 4,     // consecutive good intervals for lock (1..15)
   parameter int CBITS  = 12,    // gap counter width, 2^CBITS-1 >= PERIOD+TOL
   parameter int TCW    = 16     // tick_cnt width
) (
   input  logic             clk,
   input  logic             rst,       // asynchronous, active-low
   input  logic             tick,
   input  logic             clr,
   output logic             locked,
   output logic             fault,
   output logic             good,
   output logic             early,
   output logic             late,
   output logic [1:0]       state,
   output logic [TCW-1:0]   tick_cnt,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {
      ST_SEEK   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

   // Interval limits are one bit wider than the gap counter so that gap+1
   // never overflows when it is compared against them.
   localparam logic [CBITS:0]   LO_LIM   = (CBITS+1)'(PERIOD - TOL);
   localparam logic [CBITS:0]   HI_LIM   = (CBITS+1)'(PERIOD + TOL);
   localparam logic [CBITS:0]   INT_ONE  = (CBITS+1)'(1);
   localparam logic [CBITS-1:0] GAP_ZERO = {CBITS{1'b0}};
   localparam logic [CBITS-1:0] GAP_ONE  = CBITS'(1);
   localparam logic [CBITS-1:0] GAP_MAX  = {CBITS{1'b1}};
   localparam logic [3:0]       LOCK_RUN = 4'(LOCK);
   localparam logic [TCW-1:0]   TCNT_ONE = TCW'(1);

   state_e           state_q, state_d;
   logic [CBITS-1:0] gap_q, gap_d;
   logic [3:0]       run_q, run_d;
   logic             late_armed_q, late_armed_d;
   logic             locked_q, locked_d;
   logic             fault_q, fault_d;
   logic             good_q, good_d;
   logic             early_q, early_d;
   logic             late_q, late_d;
   logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [CBITS:0]   interval_s;
   logic             ref_valid_s;
   logic             classify_s;
   logic             good_s;
   logic             early_s;
   logic             late_s;

   // Classify the current cycle: good/early on a referenced tick, late on a missing tick
   always_comb begin
      interval_s  = {1'b0, gap_q} + INT_ONE;
      ref_valid_s = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
      // A tick following a late event has no usable reference; it only re-arms.
      classify_s  = tick && ref_valid_s && late_armed_q;
      good_s      = classify_s && (interval_s >= LO_LIM) && (interval_s <= HI_LIM);
      early_s     = classify_s && (interval_s < LO_LIM);
      // A tick in the timeout cycle wins over the late condition.
      late_s      = ref_valid_s && late_armed_q && !tick && (interval_s == HI_LIM);
   end

   // Gap counter, late arming and the tick/error counters
   always_comb begin
      gap_d        = gap_q;
      late_armed_d = late_armed_q;
      tick_cnt_d   = tick_cnt_q;
      err_cnt_d    = err_cnt_q;

      if (tick) begin
         gap_d = GAP_ZERO;
      end else if (gap_q == GAP_MAX) begin
         gap_d = gap_q;
      end else begin
         gap_d = gap_q + GAP_ONE;
      end

      if (tick) begin
         late_armed_d = 1'b1;
      end else if (late_s) begin
         late_armed_d = 1'b0;
      end else begin
         late_armed_d = late_armed_q;
      end

      if (tick) begin
         tick_cnt_d = tick_cnt_q + TCNT_ONE;
      end else begin
         tick_cnt_d = tick_cnt_q;
      end

      if ((early_s || late_s) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Lock FSM next state, good-run counter and registered status outputs
   always_comb begin
      state_d = state_q;
      run_d   = run_q;

      case (state_q)
         ST_SEEK: begin
            if (tick) begin
               state_d = ST_ACQ;
               run_d   = 4'd0;
            end else begin
               state_d = ST_SEEK;
            end
         end
         ST_ACQ: begin
            if (good_s) begin
               run_d = run_q + 4'd1;
               if ((run_q + 4'd1) == LOCK_RUN) begin
                  state_d = ST_LOCKED;
               end else begin
                  state_d = ST_ACQ;
               end
            end else if (early_s) begin
               // The early tick becomes the new reference.
               run_d   = 4'd0;
               state_d = ST_ACQ;
            end else if (late_s) begin
               run_d   = 4'd0;
               state_d = ST_SEEK;
            end else begin
               state_d = ST_ACQ;
            end
         end
         ST_LOCKED: begin
            if (early_s || late_s) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         ST_FAULT: begin
            if (clr) begin
               run_d = 4'd0;
               // A tick coincident with clr is taken as the new reference.
               if (tick) begin
                  state_d = ST_ACQ;
               end else begin
                  state_d = ST_SEEK;
               end
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d = ST_SEEK;
            run_d   = 4'd0;
         end
      endcase

      locked_d = (state_d == ST_LOCKED);
      fault_d  = (state_d == ST_FAULT);
      good_d   = good_s;
      early_d  = early_s;
      late_d   = late_s;
   end

   // State and output registers, cleared asynchronously by rst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_SEEK;
         gap_q        <= GAP_ZERO;
         run_q        <= 4'd0;
         late_armed_q <= 1'b0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
         good_q       <= 1'b0;
         early_q      <= 1'b0;
         late_q       <= 1'b0;
         tick_cnt_q   <= {TCW{1'b0}};
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         run_q        <= run_d;
         late_armed_q <= late_armed_d;
         locked_q     <= locked_d;
         fault_q      <= fault_d;
         good_q       <= good_d;
         early_q      <= early_d;
         late_q       <= late_d;
         tick_cnt_q   <= tick_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign locked   = locked_q;
   assign fault    = fault_q;
   assign good     = good_q;
   assign early    = early_q;
   assign late     = late_q;
   assign state    = state_q;
   assign tick_cnt = tick_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule
